interrupt_controller: RTL

- Owns the Game Boy interrupt flag register IF (0xFF0F) and interrupt enable register IE (0xFFFF).
- Turns hardware request lines from the timer, PPU, serial and joypad into sticky pending flags using rising-edge detection.
- Presents the highest-priority enabled interrupt to the CPU and clears it on a one-cycle acknowledge handshake.
- Sits between the MMU register bus, the peripheral request lines and the CPU, replacing the ad-hoc pending-flag logic in the system top.

---
 rtl/int_pkg.sv | 20 ++
 rtl/int_priority_enc.sv | 25 ++
 rtl/interrupt_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: source indices, register
// addresses of IF/IE on the MMU bus, and the offer FSM state encoding.
package int_pkg;

    localparam int unsigned INT_VBLANK = 0;
    localparam int unsigned INT_STAT   = 1;
    localparam int unsigned INT_TIMER  = 2;
    localparam int unsigned INT_SERIAL = 3;
    localparam int unsigned INT_JOYPAD = 4;

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } int_state_e;

endpackage

// File: rtl/int_priority_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   req  in  NUM_SRC  request vector
//   any  out 1        some request bit is set
//   id   out 3        index of the lowest set bit (0 when none set)
module int_priority_enc #(
    parameter int unsigned NUM_SRC = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [2:0]         id
);

    always_comb begin
        any = |req;
        id  = 3'd0;
        // Scan downwards so the lowest set bit is the last one assigned.
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: owns IF (0xFF0F) and IE (0xFFFF), turns
// peripheral request levels into sticky pending flags on rising edges, and
// offers the highest-priority enabled interrupt to the CPU.
// Ports:
//   clk, rst                 clock, async active-low reset
//   addr, wr_data, wr_enable MMU write interface
//   rd_enable, rd_data,
//   rd_hit                   MMU read interface (combinational)
//   hw_req                   peripheral request levels
//   int_valid, int_id,
//   int_vector, int_ack      CPU offer / acknowledge handshake
//   wake                     any enabled interrupt pending (HALT exit)
module interrupt_controller
    import int_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        addr,
    input  logic [7:0]         wr_data,
    input  logic               wr_enable,
    input  logic               rd_enable,
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    input  logic [NUM_SRC-1:0] hw_req,
    output logic               int_valid,
    output logic [2:0]         int_id,
    output logic [7:0]         int_vector,
    input  logic               int_ack,
    output logic               wake
);

    logic [NUM_SRC-1:0] if_q, if_d, prev_q, edge_det, pend, clear, base;
    logic [7:0]         ie_q, if_rd;
    int_state_e         state_q, state_d;
    logic               any;
    logic [2:0]         win_id;
    logic               ack_take;

    assign edge_det = hw_req & ~prev_q;
    assign pend     = if_q & ie_q[NUM_SRC-1:0];
    assign wake     = |pend;

    int_priority_enc #(
        .NUM_SRC(NUM_SRC)
    ) u_enc (
        .req(pend),
        .any(any),
        .id (win_id)
    );

    // Offer is withdrawn in the same cycle pend collapses, so the CPU never
    // sees a valid with nothing behind it; an ack then is ignored.
    assign int_valid  = (state_q == OFFER) && any;
    assign ack_take   = int_valid && int_ack;
    assign int_id     = int_valid ? win_id : 3'd0;
    assign int_vector = VEC_BASE + 8'(VEC_STRIDE) * {5'd0, int_id};

    always_comb begin
        base = (wr_enable && addr == ADDR_IF) ? wr_data[NUM_SRC-1:0] : if_q;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            clear[i] = ack_take && (win_id == 3'(i));
        end
        // Edge is OR'd last so a new request beats both write and ack.
        if_d = (base & ~clear) | edge_det;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any) state_d = OFFER;
            OFFER: begin
                if (ack_take)  state_d = HOLD;
                else if (!any) state_d = IDLE;
            end
            HOLD:    state_d = any ? OFFER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_q    <= '0;
            ie_q    <= 8'h00;
            prev_q  <= '0;
            state_q <= IDLE;
        end else begin
            if_q    <= if_d;
            prev_q  <= hw_req;
            state_q <= state_d;
            if (wr_enable && addr == ADDR_IE) begin
                ie_q <= wr_data;
            end
        end
    end

    always_comb begin
        if_rd                = 8'hFF;
        if_rd[NUM_SRC-1:0]   = if_q;
        rd_hit               = rd_enable && (addr == ADDR_IF || addr == ADDR_IE);
        rd_data              = 8'h00;
        if (rd_enable && addr == ADDR_IF) begin
            rd_data = if_rd;
        end else if (rd_enable && addr == ADDR_IE) begin
            rd_data = ie_q;
        end
    end

endmodule
